ps2_hex_entry: RTL and testbench
================================

PS2_HEX_ENTRY -- requirements
Module: ps2_hex_entry

Interface
REQ-001 Parameter DIGITS, default 8: number of hex nibbles held; legal range 1..16.
REQ-002 Parameter OUT_W, default 4*DIGITS: width of the entry and output words.
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 scan_data  in  8  byte from the PS2 controller (received_data).
REQ-006 scan_en  in  1  one-cycle strobe qualifying scan_data.
REQ-007 entry  out  OUT_W  live entry word, right-justified, for seven-segment display.
REQ-008 digit_count  out  $clog2(DIGITS+1)  number of nibbles currently entered.
REQ-009 out_data  out  OUT_W  captured word, stable while out_valid is high.
REQ-010 out_valid  out  1  captured word pending.
REQ-011 out_ready  in  1  consumer accepts out_data.
REQ-012 submit  out  1  one-cycle pulse on the submit key.
REQ-013 overrun  out  1  sticky flag: Enter arrived while out_valid was high.

Function
REQ-014 Decoder states: MAKE, BREAK, EXT, EXT_BREAK; an action fires only on key release.
REQ-015 MAKE: F0 -> BREAK; E0 -> EXT; any other byte is ignored.
REQ-016 EXT: F0 -> EXT_BREAK; any other byte -> MAKE.
REQ-017 BREAK: the next byte is the released key; act on it, then -> MAKE.
REQ-018 EXT_BREAK: the next byte is the released key; 5A (keypad Enter) acts as Enter, all others ignored; -> MAKE.
REQ-019 Hex keys: 45,16,1E,26,25,2E,36,3D,3E,46 map to 0-9; 1C,32,21,23,24,2B map to A-F.
REQ-020 Hex key with digit_count<DIGITS: entry <= {entry[OUT_W-5:0],nibble}; digit_count increments.
REQ-021 Hex key with digit_count==DIGITS: the key is dropped; no change to entry or digit_count.
REQ-022 Enter (5A) with out_valid low: out_data <= entry; out_valid <= 1; entry and digit_count clear, all on the same edge.
REQ-023 Enter with out_valid high: overrun <= 1; entry, digit_count and out_data are unchanged.
REQ-024 Enter with digit_count==0 is legal: it captures zero.
REQ-025 Submit (1B, release): submit pulses for 1 cycle; entry and digit_count clear; out_valid is unaffected.
REQ-026 Handshake: out_valid clears on the cycle after out_valid&&out_ready; out_data holds until then.
REQ-027 Enter and acceptance on the same edge: the acceptance completes first, then a new capture; out_valid stays high with the new data and overrun is not set.
REQ-028 Action latency: 1 cycle from the scan_en edge carrying the released key to the updated outputs.
REQ-029 overrun clears only on reset.

Reset
REQ-030 While reset_n=0 at the clock edge, all of the following clear to 0 and the decoder goes to MAKE: entry, digit_count, out_data, out_valid, submit, overrun.
REQ-031 Reset mid-sequence (e.g. after F0) discards the pending release and the pending out_valid.

Configuration
REQ-032 Macro PS2_HEX_BACKSPACE_EN defined: Backspace release (66) does entry >>= 4 and decrements digit_count; at 0 it is ignored.
REQ-033 Macro PS2_HEX_BACKSPACE_EN undefined: 66 is ignored like any unmapped key; no backspace logic is built.

Structure
REQ-034 Package ps2_input_pkg holds the scancode constants (F0, E0, 5A, 1B, 66) and the decoder state enum.
REQ-035 Sub-module ps2_scan_decode is combinational: 8-bit code -> 4-bit nibble plus is_hex flag.

Verification
REQ-036 Reset, then release 16,1E,26 (each as F0,xx) -> entry=0x123, digit_count=3.
REQ-037 DIGITS=8: release 9 hex keys -> the ninth is dropped; entry holds the first 8; digit_count=8.
REQ-038 Enter with out_ready=0, then Enter again -> out_valid=1; out_data=first word; overrun=1.
REQ-039 E0,F0,5A with entry=0xAB -> out_data=0xAB; out_valid=1; entry=0.
REQ-040 Make codes only (16 without F0) -> no change; F0,1B -> submit pulses exactly 1 cycle.
REQ-041 With PS2_HEX_BACKSPACE_EN, entry=0x123 then F0,66 -> entry=0x12, digit_count=2.

Source files
------------

// File: rtl/ps2_input_pkg.sv
// Shared PS/2 scancode constants and the make/break decoder state type
// for the hex-entry keypad block.
package ps2_input_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SUBMIT = 8'h1B;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  typedef enum logic [1:0] {
    ST_MAKE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } dec_state_e;

endpackage

// File: rtl/ps2_scan_decode.sv
// Combinational PS/2 set-2 scancode to hex nibble lookup (0-9, A-F keys).
module ps2_scan_decode (
  input  logic [7:0] code_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o
);

  always_comb begin
    nibble_o = 4'h0;
    is_hex_o = 1'b1;
    case (code_i)
      8'h45: nibble_o = 4'h0;
      8'h16: nibble_o = 4'h1;
      8'h1E: nibble_o = 4'h2;
      8'h26: nibble_o = 4'h3;
      8'h25: nibble_o = 4'h4;
      8'h2E: nibble_o = 4'h5;
      8'h36: nibble_o = 4'h6;
      8'h3D: nibble_o = 4'h7;
      8'h3E: nibble_o = 4'h8;
      8'h46: nibble_o = 4'h9;
      8'h1C: nibble_o = 4'hA;
      8'h32: nibble_o = 4'hB;
      8'h21: nibble_o = 4'hC;
      8'h23: nibble_o = 4'hD;
      8'h24: nibble_o = 4'hE;
      8'h2B: nibble_o = 4'hF;
      default: is_hex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_hex_entry.sv
// PS/2 hex keypad entry: key releases build a hex word, Enter captures it
// behind a valid/ready handshake. Define PS2_HEX_BACKSPACE_EN to enable Backspace (66).
//
// state        | meaning
// ST_MAKE      | idle / make codes, waiting for F0 or E0
// ST_BREAK     | F0 seen, next byte is the released key
// ST_EXT       | E0 seen, waiting for F0 of an extended release
// ST_EXT_BREAK | E0 F0 seen, next byte is the released extended key
module ps2_hex_entry
  import ps2_input_pkg::*;
#(
  parameter  int DIGITS = 8,
  parameter  int OUT_W  = 4 * DIGITS,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [7:0]       scan_data,
  input  logic             scan_en,
  output logic [OUT_W-1:0] entry,
  output logic [CW-1:0]    digit_count,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             submit,
  output logic             overrun
);

  dec_state_e       state_q, state_d;
  logic [OUT_W-1:0] entry_q, entry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             submit_q, submit_d;
  logic             overrun_q, overrun_d;

  logic [3:0]       nibble;
  logic             is_hex;
  logic             rel_std;
  logic             rel_ext;

  ps2_scan_decode u_decode (
    .code_i   (scan_data),
    .nibble_o (nibble),
    .is_hex_o (is_hex)
  );

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    submit_d    = 1'b0;
    overrun_d   = overrun_q;
    rel_std     = 1'b0;
    rel_ext     = 1'b0;

    // Acceptance retires first so a same-edge Enter sees an empty slot.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (scan_en) begin
      case (state_q)
        ST_MAKE: begin
          if (scan_data == SC_BREAK)    state_d = ST_BREAK;
          else if (scan_data == SC_EXT) state_d = ST_EXT;
        end
        ST_EXT: begin
          if (scan_data == SC_BREAK) state_d = ST_EXT_BREAK;
          else                       state_d = ST_MAKE;
        end
        ST_BREAK: begin
          rel_std = 1'b1;
          state_d = ST_MAKE;
        end
        ST_EXT_BREAK: begin
          rel_ext = 1'b1;
          state_d = ST_MAKE;
        end
        default: state_d = ST_MAKE;
      endcase
    end

    if ((rel_std || rel_ext) && scan_data == SC_ENTER) begin
      if (!out_valid_d) begin
        out_data_d  = entry_q;
        out_valid_d = 1'b1;
        entry_d     = '0;
        cnt_d       = '0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rel_std && is_hex) begin
      if (cnt_q < CW'(DIGITS)) begin
        entry_d = OUT_W'({entry_q, nibble});
        cnt_d   = cnt_q + CW'(1);
      end
    end else if (rel_std && scan_data == SC_SUBMIT) begin
      submit_d = 1'b1;
      entry_d  = '0;
      cnt_d    = '0;
    end
`ifdef PS2_HEX_BACKSPACE_EN
    else if (rel_std && scan_data == SC_BKSP) begin
      if (cnt_q != '0) begin
        entry_d = entry_q >> 4;
        cnt_d   = cnt_q - CW'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q     <= ST_MAKE;
      entry_q     <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      submit_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      submit_q    <= submit_d;
      overrun_q   <= overrun_d;
    end
  end

  assign entry       = entry_q;
  assign digit_count = cnt_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign submit      = submit_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Bench for ps2_hex_entry: vector table, corner sequences, then random bytes
// against a frame-parsing reference model. Honors PS2_HEX_BACKSPACE_EN.
module tb_ps2_hex_entry;

  localparam int DIGITS = 8;
  localparam int OUT_W  = 4 * DIGITS;
  localparam int CW     = $clog2(DIGITS + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       scan_data;
  logic             scan_en;
  logic             out_ready;
  logic [OUT_W-1:0] entry;
  logic [CW-1:0]    digit_count;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             submit;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_hex_entry #(.DIGITS(DIGITS)) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .scan_data   (scan_data),
    .scan_en     (scan_en),
    .entry       (entry),
    .digit_count (digit_count),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .submit      (submit),
    .overrun     (overrun)
  );

  // Key codes in nibble order 0..F.
  logic [7:0] hexkeys [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  // Reference model: nibbles as a queue, bytes grouped into frames.
  logic [3:0]       m_nibs [$];
  logic [7:0]       m_frame [$];
  logic [OUT_W-1:0] m_out;
  logic             m_valid, m_submit, m_ovr;

  function automatic logic [63:0] m_entry();
    logic [63:0] v = '0;
    foreach (m_nibs[i]) v = (v << 4) | 64'(m_nibs[i]);
    return v;
  endfunction

  function automatic int hex_of(logic [7:0] k);
    for (int i = 0; i < 16; i++) if (hexkeys[i] == k) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_nibs.delete(); m_frame.delete();
    m_out = '0; m_valid = 0; m_submit = 0; m_ovr = 0;
  endtask

  task automatic model_step(logic en, logic [7:0] d, logic rdy);
    logic       rel = 0, ext = 0;
    logic [7:0] k = 8'h00;
    logic       slot_busy;
    int         h;
    slot_busy = m_valid && !rdy;
    m_submit = 0;
    if (en) begin
      m_frame.push_back(d);
      if (m_frame.size() == 1 && d != 8'hF0 && d != 8'hE0) m_frame.delete();
      else if (m_frame.size() == 2 && m_frame[0] == 8'hF0) begin
        rel = 1; k = d; m_frame.delete();
      end else if (m_frame.size() == 2 && d != 8'hF0) m_frame.delete();
      else if (m_frame.size() == 3) begin
        rel = 1; ext = 1; k = d; m_frame.delete();
      end
    end
    if (rel) begin
      h = hex_of(k);
      if (k == 8'h5A) begin
        if (!slot_busy) begin
          m_out = OUT_W'(m_entry()); slot_busy = 1; m_nibs.delete();
        end else m_ovr = 1;
      end else if (!ext) begin
        if (h >= 0) begin
          if (m_nibs.size() < DIGITS) m_nibs.push_back(4'(h));
        end else if (k == 8'h1B) begin
          m_submit = 1; m_nibs.delete();
        end
`ifdef PS2_HEX_BACKSPACE_EN
        else if (k == 8'h66 && m_nibs.size() > 0) void'(m_nibs.pop_back());
`endif
      end
    end
    m_valid = slot_busy;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_entry", 64'(entry), m_entry());
    chk("m_count", 64'(digit_count), 64'(m_nibs.size()));
    chk("m_out_data", 64'(out_data), 64'(m_out));
    chk("m_out_valid", 64'(out_valid), 64'(m_valid));
    chk("m_submit", 64'(submit), 64'(m_submit));
    chk("m_overrun", 64'(overrun), 64'(m_ovr));
  endtask

  // Drive at negedge, clock, update model, compare at next negedge.
  task automatic step(logic en, logic [7:0] d, logic rdy);
    scan_en = en; scan_data = d; out_ready = rdy;
    @(posedge clk);
    model_step(en, d, rdy);
    @(negedge clk);
    check_model();
  endtask

  task automatic rel(logic [7:0] k);
    step(1, 8'hF0, 0);
    step(1, k, 0);
  endtask

  task automatic do_reset();
    reset_n = 0; scan_en = 0; scan_data = 8'h00; out_ready = 0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    check_model();
  endtask

  typedef struct {
    logic             en;
    logic [7:0]       data;
    logic             rdy;
    logic [OUT_W-1:0] e_entry;
    logic [CW-1:0]    e_cnt;
    logic [OUT_W-1:0] e_out;
    logic             e_valid;
    logic             e_sub;
    logic             e_ovr;
  } vec_t;

  vec_t tbl [$];

  task automatic add(logic en, logic [7:0] d, logic rdy, logic [OUT_W-1:0] ee,
                     logic [CW-1:0] ec, logic [OUT_W-1:0] eo, logic ev, logic es, logic eovr);
    vec_t v;
    v.en = en; v.data = d; v.rdy = rdy; v.e_entry = ee; v.e_cnt = ec;
    v.e_out = eo; v.e_valid = ev; v.e_sub = es; v.e_ovr = eovr;
    tbl.push_back(v);
  endtask

  initial begin
    reset_n = 0; scan_en = 0; scan_data = 8'h00; out_ready = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_entry", 64'(entry), 64'h0);
    chk("reset_count", 64'(digit_count), 64'h0);
    chk("reset_valid", 64'(out_valid), 64'h0);

    //   en data   rdy entry  cnt out    v  s  ovr
    add(1, 8'hF0, 0, 'h0,   0, 'h0,   0, 0, 0);
    add(1, 8'h16, 0, 'h1,   1, 'h0,   0, 0, 0);
    add(1, 8'hF0, 0, 'h1,   1, 'h0,   0, 0, 0);
    add(1, 8'h1E, 0, 'h12,  2, 'h0,   0, 0, 0);
    add(1, 8'hF0, 0, 'h12,  2, 'h0,   0, 0, 0);
    add(1, 8'h26, 0, 'h123, 3, 'h0,   0, 0, 0);
    add(1, 8'h16, 0, 'h123, 3, 'h0,   0, 0, 0);
    add(0, 8'h00, 0, 'h123, 3, 'h0,   0, 0, 0);
    add(1, 8'hE0, 0, 'h123, 3, 'h0,   0, 0, 0);
    add(1, 8'hF0, 0, 'h123, 3, 'h0,   0, 0, 0);
    add(1, 8'h5A, 0, 'h0,   0, 'h123, 1, 0, 0);
    add(1, 8'hF0, 0, 'h0,   0, 'h123, 1, 0, 0);
    add(1, 8'h16, 0, 'h1,   1, 'h123, 1, 0, 0);
    add(1, 8'hF0, 0, 'h1,   1, 'h123, 1, 0, 0);
    add(1, 8'h5A, 0, 'h1,   1, 'h123, 1, 0, 1);
    add(0, 8'h00, 1, 'h1,   1, 'h123, 0, 0, 1);
    add(1, 8'hF0, 0, 'h1,   1, 'h123, 0, 0, 1);
    add(1, 8'h2B, 0, 'h1F,  2, 'h123, 0, 0, 1);
    add(1, 8'hF0, 0, 'h1F,  2, 'h123, 0, 0, 1);
    add(1, 8'h1B, 0, 'h0,   0, 'h123, 0, 1, 1);
    add(0, 8'h00, 0, 'h0,   0, 'h123, 0, 0, 1);
    add(1, 8'hF0, 0, 'hA,   0, 'h123, 0, 0, 1);
    tbl[tbl.size()-1].e_entry = 'h0;
    add(1, 8'h1C, 0, 'hA,   1, 'h123, 0, 0, 1);
    add(1, 8'hF0, 0, 'hA,   1, 'h123, 0, 0, 1);
    add(1, 8'h32, 0, 'hAB,  2, 'h123, 0, 0, 1);
    add(1, 8'hE0, 0, 'hAB,  2, 'h123, 0, 0, 1);
    add(1, 8'hF0, 0, 'hAB,  2, 'h123, 0, 0, 1);
    add(1, 8'h16, 0, 'hAB,  2, 'h123, 0, 0, 1);
    add(1, 8'hE0, 0, 'hAB,  2, 'h123, 0, 0, 1);
    add(1, 8'hF0, 0, 'hAB,  2, 'h123, 0, 0, 1);
    add(1, 8'h5A, 0, 'h0,   0, 'hAB,  1, 0, 1);

    foreach (tbl[i]) begin
      scan_en = tbl[i].en; scan_data = tbl[i].data; out_ready = tbl[i].rdy;
      @(posedge clk);
      model_step(tbl[i].en, tbl[i].data, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_entry", i), 64'(entry), 64'(tbl[i].e_entry));
      chk($sformatf("tbl%0d_count", i), 64'(digit_count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_out", i), 64'(out_data), 64'(tbl[i].e_out));
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_submit", i), 64'(submit), 64'(tbl[i].e_sub));
      chk($sformatf("tbl%0d_overrun", i), 64'(overrun), 64'(tbl[i].e_ovr));
    end

    // Nine keys into eight digits: the ninth is dropped.
    do_reset();
    for (int i = 1; i <= 9; i++) rel(hexkeys[i]);
    chk("full_entry", 64'(entry), 64'h12345678);
    chk("full_count", 64'(digit_count), 64'd8);

    // Enter on the same edge as acceptance: new capture, no overrun.
    rel(8'h5A);
    chk("cap_out", 64'(out_data), 64'h12345678);
    rel(hexkeys[2]);
    step(1, 8'hF0, 0);
    step(1, 8'h5A, 1);
    chk("same_edge_valid", 64'(out_valid), 64'h1);
    chk("same_edge_out", 64'(out_data), 64'h2);
    chk("same_edge_ovr", 64'(overrun), 64'h0);

    // Reset after F0 drops the pending release and the pending word.
    step(1, 8'hF0, 0);
    do_reset();
    step(1, 8'h16, 0);
    chk("rst_mid_entry", 64'(entry), 64'h0);
    chk("rst_mid_valid", 64'(out_valid), 64'h0);

    do_reset();
    rel(8'h16); rel(8'h1E); rel(8'h26);
    rel(8'h66);
`ifdef PS2_HEX_BACKSPACE_EN
    chk("bksp_entry", 64'(entry), 64'h12);
    chk("bksp_count", 64'(digit_count), 64'd2);
`else
    chk("bksp_entry", 64'(entry), 64'h123);
    chk("bksp_count", 64'(digit_count), 64'd3);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      int         r;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        continue;
      end
      r = $urandom_range(0, 9);
      if (r <= 2)      b = 8'hF0;
      else if (r == 3) b = 8'hE0;
      else if (r <= 6) b = hexkeys[$urandom_range(0, 15)];
      else if (r == 7) b = 8'h5A;
      else if (r == 8) b = ($urandom_range(0, 1) == 0) ? 8'h1B : 8'h66;
      else             b = 8'($urandom);
      step($urandom_range(0, 2) != 0, b, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
